// File: rtl/ahblite_uart_tx.sv
// AHB-Lite transmit-only 8N1 UART: write FIFO, programmable baud divisor,
// wait-state stretching on a full FIFO, two-cycle ERROR for offset 0xC.
//
// Transmitter states
//   state   | meaning
//   --------+--------------------------------------------------------
//   S_IDLE  | line idle (TXD=1), waiting for the FIFO to become non-empty
//   S_START | start bit (TXD=0), byte already popped into shift_q
//   S_DATA  | eight data bits, LSB first (TXD=shift_q[0])
//   S_STOP  | stop bit (TXD=1), chains straight into S_START if data waits
module ahblite_uart_tx #(
   parameter int          FIFO_DEPTH = 16,
   parameter logic [15:0] BAUD_RESET = 16'd433
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic        TXD,
   output logic        TX_IRQ
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   logic            dp_valid;
   logic            dp_write;
   logic [1:0]      dp_addr;
   logic            err1;
   logic            err2;
   logic            wr_data;
   logic            baud_wr;
   logic            push;
   logic            pop;
   logic            reload;
   logic            bit_done;
   logic            fifo_empty;
   logic            fifo_full;
   logic            busy;
   logic [7:0]      fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [15:0]     baud_div;
   logic [15:0]     bit_cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shift_q;
   logic [31:0]     status_word;
   tx_state_t       state_q;
   tx_state_t       state_d;
   logic            unused_ok;

   // Only HADDR[3:2] and the low half of HWDATA carry meaning; HSIZE is ignored.
   assign unused_ok = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

   // Capture the address phase; hold it while the data phase is stretched.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= 2'd0;
      end else if (HREADY) begin
         dp_valid <= HSEL & HTRANS[1];
         if (HSEL & HTRANS[1]) begin
            dp_addr  <= HADDR[3:2];
            dp_write <= HWRITE;
         end
      end
   end

   assign err1    = dp_valid & (dp_addr == 2'd3) & ~err2;
   assign wr_data = dp_valid & dp_write & (dp_addr == 2'd0);
   assign baud_wr = dp_valid & dp_write & (dp_addr == 2'd2);

   // Full is judged on the registered count, so a same-cycle pop still costs
   // one wait state; the push then lands in the following cycle.
   assign HREADYOUT = ~(err1 | (wr_data & fifo_full));
   assign HRESP     = err1 | err2;
   assign push      = wr_data & ~fifo_full;

   // Second cycle of the ERROR response.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) err2 <= 1'b0;
      else          err2 <= err1;
   end

   // Baud divisor register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn)     baud_div <= BAUD_RESET;
      else if (baud_wr) baud_div <= HWDATA[15:0];
   end

   // FIFO storage; contents need no reset since count gates every read.
   always_ff @(posedge HCLK) begin
      if (push) fifo_mem[wr_ptr] <= HWDATA[7:0];
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign busy       = (state_q != S_IDLE);
   assign TX_IRQ     = fifo_empty & ~busy;

   // Status word assembly and read-data mux for the current data phase.
   always_comb begin
      status_word         = '0;
      status_word[0]      = fifo_empty;
      status_word[1]      = fifo_full;
      status_word[2]      = busy;
      status_word[3 +: CW] = count;
      HRDATA              = '0;
      if (dp_valid && !dp_write) begin
         case (dp_addr)
            2'd1:    HRDATA = status_word;
            2'd2:    HRDATA = {16'h0000, baud_div};
            default: HRDATA = '0;
         endcase
      end
   end

   // Transmitter state register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Next state, pop and bit-timer reload decisions.
   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      reload   = 1'b0;
      bit_done = (bit_cnt == 16'd0);
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_START;
               pop     = 1'b1;
               reload  = 1'b1;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_d = S_DATA;
               reload  = 1'b1;
            end
         end
         S_DATA: begin
            if (bit_done) begin
               reload = 1'b1;
               if (bit_idx == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_done) begin
               if (!fifo_empty) begin
                  state_d = S_START;
                  pop     = 1'b1;
                  reload  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Bit timer, bit index and shift register; a new divisor is picked up
   // only at a reload, so the bit in flight keeps its length.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         bit_cnt <= 16'd0;
         bit_idx <= 3'd0;
         shift_q <= 8'd0;
      end else begin
         if (reload)
            bit_cnt <= baud_div;
         else if (busy && !bit_done)
            bit_cnt <= bit_cnt - 1'b1;

         if (state_q == S_START)
            bit_idx <= 3'd0;
         else if (state_q == S_DATA && bit_done)
            bit_idx <= bit_idx + 1'b1;

         if (pop)
            shift_q <= fifo_mem[rd_ptr];
         else if (state_q == S_DATA && bit_done)
            shift_q <= {1'b0, shift_q[7:1]};
      end
   end

   // Line level follows the state directly so reset forces it high at once.
   always_comb begin
      case (state_q)
         S_START: TXD = 1'b0;
         S_DATA:  TXD = shift_q[0];
         default: TXD = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_ahblite_uart_tx.sv
// Self-checking bench for ahblite_uart_tx: bus sequencer, serial frame
// checker and a queue of bytes expected on the line.
module tb_ahblite_uart_tx;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        TXD;
   logic        TX_IRQ;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int baud_model;

   logic [31:0] op_addr  [64];
   logic [31:0] op_wdata [64];
   logic        op_wr    [64];
   logic [31:0] res_rdata  [64];
   int          res_waits  [64];
   int          res_cyc    [64];
   logic        res_ready0 [64];
   logic        res_resp0  [64];
   logic        res_resp   [64];
   logic [7:0]  exp_q[$];

   // Single-slave system: the mux ready is this slave's ready.
   assign HREADY = HREADYOUT;

   ahblite_uart_tx #(.FIFO_DEPTH(16), .BAUD_RESET(16'd433)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .HRDATA(HRDATA), .TXD(TXD), .TX_IRQ(TX_IRQ)
   );

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   function automatic logic [31:0] rnd_hi(input logic [31:0] off);
      return ($urandom & 32'hFFFF_FFF0) | off;
   endfunction

   task automatic set_op(input int i, input logic [31:0] addr, input logic wr, input logic [31:0] data);
      op_addr[i]  = addr;
      op_wr[i]    = wr;
      op_wdata[i] = data;
   endtask

   // Pipelined AHB master: address of op i overlaps the data phase of op i-1.
   task automatic bus_run(input int n);
      for (int i = 0; i <= n; i++) begin
         @(negedge HCLK);
         if (i < n) begin
            HSEL = 1'b1; HTRANS = 2'b10; HADDR = op_addr[i]; HWRITE = op_wr[i];
            HSIZE = 3'($urandom_range(0, 2));
         end else begin
            HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0;
         end
         if (i > 0) begin
            int w = 0;
            HWDATA = op_wr[i-1] ? op_wdata[i-1] : $urandom;
            res_ready0[i-1] = HREADYOUT;
            res_resp0[i-1]  = HRESP;
            while (!HREADYOUT && w < 3000) begin
               @(negedge HCLK);
               w++;
            end
            checks++;
            if (!HREADYOUT) begin
               failures++;
               $display("FAIL bus_timeout op=%0d: HREADYOUT=%b after %0d waits, required 1", i-1, HREADYOUT, w);
            end
            res_waits[i-1] = w;
            res_rdata[i-1] = HRDATA;
            res_resp[i-1]  = HRESP;
            res_cyc[i-1]   = cyc;
         end
      end
   endtask

   // Waits for a start bit, then checks every cycle of all ten bit cells.
   task automatic check_frame(input logic [7:0] b, input int baud, input string name, output int start_cyc);
      logic [9:0] bits;
      int n = 0;
      bits = {1'b1, b, 1'b0};
      start_cyc = -1;
      @(negedge HCLK);
      while (TXD !== 1'b0 && n < 3000) begin
         @(negedge HCLK);
         n++;
      end
      checks++;
      if (TXD !== 1'b0) begin
         failures++;
         $display("FAIL %s_start: TXD=%b after %0d cycles, required 0", name, TXD, n);
         return;
      end
      start_cyc = cyc;
      for (int bi = 0; bi < 10; bi++) begin
         logic bad = 1'b0;
         logic got = bits[bi];
         for (int c = 0; c <= baud; c++) begin
            if (!(bi == 0 && c == 0)) @(negedge HCLK);
            if (TXD !== bits[bi]) begin bad = 1'b1; got = TXD; end
         end
         checks++;
         if (bad) begin
            failures++;
            $display("FAIL %s_bit%0d byte=%02h: TXD=%b, required %b", name, bi, b, got, bits[bi]);
         end
      end
   endtask

   task automatic test_reset;
      @(negedge HCLK);
      checks++; if (TXD !== 1'b1)       begin failures++; $display("FAIL rst_txd: got %b required 1", TXD); end
      checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rst_hreadyout: got %b required 1", HREADYOUT); end
      checks++; if (HRESP !== 1'b0)     begin failures++; $display("FAIL rst_hresp: got %b required 0", HRESP); end
      checks++; if (TX_IRQ !== 1'b1)    begin failures++; $display("FAIL rst_irq: got %b required 1", TX_IRQ); end
      checks++; if (HRDATA !== 32'h0)   begin failures++; $display("FAIL rst_hrdata: got %h required 0", HRDATA); end
      set_op(0, rnd_hi(32'h4), 1'b0, 32'h0);
      set_op(1, rnd_hi(32'h8), 1'b0, 32'h0);
      bus_run(2);
      checks++; if (res_rdata[0] !== 32'h1)   begin failures++; $display("FAIL rst_status: got %h required 00000001", res_rdata[0]); end
      checks++; if (res_rdata[1] !== 32'h1B1) begin failures++; $display("FAIL rst_baud: got %h required 000001b1", res_rdata[1]); end
   endtask

   task automatic test_frame;
      int sc;
      set_op(0, rnd_hi(32'h8), 1'b1, 32'h3);
      set_op(1, rnd_hi(32'h0), 1'b1, 32'hA5);
      bus_run(2);
      baud_model = 3;
      @(negedge HCLK);
      checks++; if (TX_IRQ !== 1'b0) begin failures++; $display("FAIL frame_irq_busy: got %b required 0", TX_IRQ); end
      check_frame(8'hA5, 3, "frame_a5", sc);
      @(negedge HCLK);
      checks++; if (TXD !== 1'b1)    begin failures++; $display("FAIL frame_txd_idle: got %b required 1", TXD); end
      checks++; if (TX_IRQ !== 1'b1) begin failures++; $display("FAIL frame_irq_done: got %b required 1", TX_IRQ); end
   endtask

   task automatic test_error;
      set_op(0, rnd_hi(32'hC), 1'b0, 32'h0);
      set_op(1, rnd_hi(32'h4), 1'b0, 32'h0);
      set_op(2, rnd_hi(32'hC), 1'b1, 32'h0000_1234);
      set_op(3, rnd_hi(32'h4), 1'b1, 32'hFFFF_FFFF);
      set_op(4, rnd_hi(32'h8), 1'b0, 32'h0);
      set_op(5, rnd_hi(32'h0), 1'b0, 32'h0);
      set_op(6, rnd_hi(32'h4), 1'b0, 32'h0);
      bus_run(7);
      for (int k = 0; k <= 2; k += 2) begin
         checks++;
         if ({res_ready0[k], res_resp0[k]} !== 2'b01 || res_waits[k] !== 1 || res_resp[k] !== 1'b1) begin
            failures++;
            $display("FAIL err_resp op%0d: ready/resp=%b%b waits=%0d final_resp=%b, required 01 waits=1 final_resp=1",
                     k, res_ready0[k], res_resp0[k], res_waits[k], res_resp[k]);
         end
      end
      checks++;
      if (res_resp0[1] !== 1'b0 || res_waits[1] !== 0 || res_rdata[1] !== 32'h1) begin
         failures++;
         $display("FAIL err_next_okay: resp=%b waits=%0d data=%h, required 0 0 00000001", res_resp0[1], res_waits[1], res_rdata[1]);
      end
      checks++;
      if (res_resp0[3] !== 1'b0 || res_waits[3] !== 0) begin
         failures++;
         $display("FAIL err_status_write: resp=%b waits=%0d, required 0 0", res_resp0[3], res_waits[3]);
      end
      checks++; if (res_rdata[4] !== 32'(baud_model)) begin failures++; $display("FAIL err_baud_kept: got %h required %h", res_rdata[4], baud_model); end
      checks++; if (res_rdata[5] !== 32'h0) begin failures++; $display("FAIL data_read_zero: got %h required 0", res_rdata[5]); end
      checks++; if (res_rdata[6] !== 32'h1) begin failures++; $display("FAIL err_status_kept: got %h required 00000001", res_rdata[6]); end
   endtask

   task automatic test_pipelined;
      int sc;
      logic [7:0] b;
      b = 8'($urandom);
      set_op(0, rnd_hi(32'h8), 1'b1, 32'h1);
      set_op(1, rnd_hi(32'h0), 1'b1, {24'($urandom), b});
      set_op(2, rnd_hi(32'h4), 1'b0, 32'h0);
      bus_run(3);
      baud_model = 1;
      checks++;
      if (res_waits[1] !== 0 || res_waits[2] !== 0) begin
         failures++;
         $display("FAIL pipe_waits: write=%0d read=%0d, required 0 0", res_waits[1], res_waits[2]);
      end
      checks++; if (res_rdata[2] !== 32'h08) begin failures++; $display("FAIL pipe_status: got %h required 00000008", res_rdata[2]); end
      check_frame(b, 1, "pipe_frame", sc);
   endtask

   task automatic test_random;
      for (int r = 0; r < 3; r++) begin
         int n;
         int baud;
         n    = $urandom_range(1, 5);
         baud = $urandom_range(0, 4);
         set_op(0, rnd_hi(32'h8), 1'b1, ($urandom & 32'hFFFF_0000) | 32'(baud));
         for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            b = 8'($urandom);
            exp_q.push_back(b);
            set_op(k + 1, rnd_hi(32'h0), 1'b1, {24'($urandom), b});
         end
         fork
            bus_run(n + 1);
            begin
               for (int k = 0; k < n; k++) begin
                  int sc;
                  check_frame(exp_q.pop_front(), baud, "rnd_frame", sc);
               end
            end
         join
         baud_model = baud;
         set_op(0, rnd_hi(32'h8), 1'b0, 32'h0);
         set_op(1, rnd_hi(32'h4), 1'b0, 32'h0);
         bus_run(2);
         checks++; if (res_rdata[0] !== 32'(baud)) begin failures++; $display("FAIL rnd_baud: got %h required %h", res_rdata[0], baud); end
         checks++; if (res_rdata[1] !== 32'h1)     begin failures++; $display("FAIL rnd_status_idle: got %h required 00000001", res_rdata[1]); end
      end
   endtask

   task automatic test_back_to_back;
      int s2;
      int sc;
      int wsum;
      set_op(0, rnd_hi(32'h8), 1'b1, 32'h7);
      set_op(1, rnd_hi(32'h0), 1'b1, 32'hFF);
      bus_run(2);
      baud_model = 7;
      repeat (12) @(negedge HCLK);
      for (int k = 0; k < 17; k++) begin
         logic [7:0] b;
         b = 8'($urandom);
         exp_q.push_back(b);
         set_op(k < 16 ? k : 17, rnd_hi(32'h0), 1'b1, {24'h0, b});
      end
      set_op(16, rnd_hi(32'h4), 1'b0, 32'h0);
      s2 = -1;
      fork
         bus_run(18);
         begin
            for (int k = 0; k < 17; k++) begin
               check_frame(exp_q.pop_front(), 7, "b2b_frame", sc);
               if (k == 0) s2 = sc;
            end
         end
      join
      wsum = 0;
      for (int k = 0; k < 16; k++) wsum += res_waits[k];
      checks++; if (wsum !== 0) begin failures++; $display("FAIL b2b_fill_waits: got %0d required 0", wsum); end
      checks++;
      if (res_rdata[16] !== 32'h86 || res_waits[16] !== 0) begin
         failures++;
         $display("FAIL b2b_status_full: got %h waits=%0d, required 00000086 waits=0", res_rdata[16], res_waits[16]);
      end
      checks++; if (res_waits[17] < 1) begin failures++; $display("FAIL b2b_stall: waits=%0d, required >0", res_waits[17]); end
      checks++;
      if (res_cyc[17] !== s2) begin
         failures++;
         $display("FAIL b2b_release_cycle: write done at cycle %0d, required %0d (cycle after pop)", res_cyc[17], s2);
      end
   endtask

   task automatic test_reset_midframe;
      int n = 0;
      int bad = 0;
      for (int k = 0; k < 4; k++) set_op(k, rnd_hi(32'h0), 1'b1, 32'h0);
      bus_run(4);
      while (TXD !== 1'b0 && n < 200) begin @(negedge HCLK); n++; end
      repeat (19) @(negedge HCLK);
      checks++; if (TXD !== 1'b0) begin failures++; $display("FAIL rm_pre_txd: got %b required 0", TXD); end
      #2 HRESETn = 1'b0;
      #1;
      checks++; if (TXD !== 1'b1)       begin failures++; $display("FAIL rm_txd_async: got %b required 1", TXD); end
      checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL rm_hreadyout: got %b required 1", HREADYOUT); end
      checks++; if (TX_IRQ !== 1'b1)    begin failures++; $display("FAIL rm_irq: got %b required 1", TX_IRQ); end
      @(negedge HCLK);
      @(negedge HCLK);
      HRESETn = 1'b1;
      baud_model = 433;
      set_op(0, rnd_hi(32'h4), 1'b0, 32'h0);
      set_op(1, rnd_hi(32'h8), 1'b0, 32'h0);
      bus_run(2);
      checks++; if (res_rdata[0] !== 32'h1)   begin failures++; $display("FAIL rm_status: got %h required 00000001", res_rdata[0]); end
      checks++; if (res_rdata[1] !== 32'h1B1) begin failures++; $display("FAIL rm_baud: got %h required 000001b1", res_rdata[1]); end
      repeat (300) begin
         @(negedge HCLK);
         if (TXD !== 1'b1) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL rm_no_frames: TXD low in %0d cycles, required 0", bad); end
   endtask

   initial begin
      HRESETn = 1'b0;
      HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b010; HWDATA = 32'h0;
      baud_model = 433;
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      test_reset();
      test_frame();
      test_error();
      test_pipelined();
      test_random();
      test_back_to_back();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahblite_uart_tx.md
Name: ahblite_uart_tx

Overview:
AHB-Lite slave that drives one port of the system slave multiplexer: it returns HREADYOUT, HRESP and HRDATA per port and takes its HSEL from the address decoder. It implements a transmit-only 8N1 UART with a write FIFO and a programmable baud divisor. Writes to a full FIFO are stretched with wait states, and unmapped offsets return a two-cycle ERROR response.

Parameters:
FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.
BAUD_RESET, 16'd433, reset value of BAUDDIV. Bit period is BAUDDIV+1 HCLK cycles.

Ports:
HCLK  in  1  system clock
HRESETn  in  1  asynchronous, active-low reset
HSEL  in  1  slave select from the decoder
HADDR  in  32  address; only [3:2] are decoded
HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
HWRITE  in  1  1 = write
HSIZE  in  3  ignored; all accesses are treated as word accesses
HWDATA  in  32  write data, valid in the data phase
HREADY  in  1  bus-wide ready, from the mux output
HREADYOUT  out  1  this slave's ready, to the mux
HRESP  out  1  0 = OKAY, 1 = ERROR
HRDATA  out  32  read data, to the mux
TXD  out  1  serial output, idle high
TX_IRQ  out  1  level: FIFO empty and transmitter idle

Behaviour:
- Reset is HRESETn, asynchronous, active-low; clock is HCLK.
- Reset values:
  - HREADYOUT=1, HRESP=0, HRDATA=0, TXD=1, TX_IRQ=1.
  - FIFO empty, BAUDDIV=BAUD_RESET, transmitter FSM in IDLE.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On acceptance the block registers HADDR[3:2], HWRITE and a valid flag. Otherwise the valid flag clears when HREADY=1.
- Register map, by HADDR[3:2]:
  - 0 DATA: write pushes HWDATA[7:0]; read returns 0.
  - 1 STATUS: read-only; {24'b0, count[4:0] (zero-extended, FIFO_DEPTH=16), busy, full, empty}. Writes are ignored with an OKAY response.
  - 2 BAUDDIV: read/write, [15:0]; upper bits read as 0.
  - 3: ERROR.
- Read data phase: zero wait states. HRDATA is driven combinationally from the registered offset during the data phase, and is 0 when no valid read is in its data phase.
- DATA write, FIFO not full: zero wait states; push at the end of the data phase (HREADYOUT=1).
- DATA write, FIFO full: HREADYOUT=0 until the FIFO is not full. The push completes in the first cycle with space.
  - A pop in the same cycle that would relieve fullness: HREADYOUT stays 0 that cycle; the write completes the next cycle.
  - HWDATA is sampled in the cycle HREADYOUT=1.
- Offset 3: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1; then back to OKAY. No register side effects.
- FIFO:
  - Circular buffer with a log2(FIFO_DEPTH)-bit pointer that wraps to 0.
  - Count is log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop leaves the count unchanged.
  - A push when full never occurs, because of the stall.
- Transmitter FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE, or STOP -> START if the FIFO is non-empty.
  - Pop occurs on the IDLE->START or STOP->START transition; the byte is latched in a shift register.
  - Each state/bit lasts BAUDDIV+1 cycles, using a down-counter reloaded at each bit boundary.
  - TXD: START=0, DATA=shift[0], STOP=1, IDLE=1.
  - busy=1 in any state other than IDLE.
- A BAUDDIV write mid-frame takes effect at the next bit-boundary reload. The current bit is not truncated.
- BAUDDIV=0 gives a 1-cycle bit period and is legal.
- Asynchronous reset mid-frame: TXD returns to 1 immediately, the FIFO is flushed, and any stalled bus transfer is abandoned with HREADYOUT=1.

Test Plan:
- Reset -> TXD=1, HREADYOUT=1, HRESP=0, TX_IRQ=1; STATUS read returns 0x00000001; BAUDDIV read returns 0x000001B1.
- BAUDDIV=3, write DATA=0xA5 -> TXD shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level held 4 cycles; TX_IRQ=0 during the frame and 1 after the stop bit.
- BAUDDIV=7, 17 back-to-back DATA writes while the first byte is transmitting -> the 17th write stalls with HREADYOUT=0 until the next pop, then completes; STATUS shows full=1 with count=16 beforehand.
- Read offset 0xC -> HREADYOUT/HRESP = 0/1 then 1/1, then the next transfer is OKAY; registers unchanged.
- Write DATA while STATUS is read back-to-back in a pipelined sequence -> the read returns the count including the just-pushed byte; no wait states on either transfer.
- Deassert HRESETn mid-DATA-bit with 3 bytes queued -> TXD=1 asynchronously; after release STATUS reads 0x00000001 and no further frames are sent.
